// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 serial receiver with mid-bit sampling and framing-error pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter logic [10:0] CLKS_9600   = 11'd1042,
    parameter logic [10:0] CLKS_14400  = 11'd695,
    parameter logic [10:0] CLKS_19200  = 11'd521,
    parameter logic [10:0] CLKS_38400  = 11'd261,
    parameter logic [10:0] CLKS_57600  = 11'd174,
    parameter logic [10:0] CLKS_115200 = 11'd87,
    parameter logic [10:0] CLKS_128000 = 11'd79,
    parameter logic [10:0] CLKS_256000 = 11'd39
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_rate_select,
    input  logic       Rx_Serial,
    output logic [7:0] Rx_Byte,
    output logic       Rx_Done,
    output logic       Frame_Error,
    output logic       Rx_Active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t      state_q;
    logic        sync1_q;
    logic        rx_sync_q;
    logic        prev_q;
    logic [10:0] div_q;
    logic [10:0] clk_count_q;
    logic [2:0]  bit_index_q;
    logic [7:0]  shift_q;
    logic [7:0]  byte_q;
    logic        done_q;
    logic        fe_q;
    logic        active_q;

    logic [10:0] baud_rate_d;
    logic [10:0] half_m1;
    logic [10:0] div_m1;

    always_comb begin
        baud_rate_d = CLKS_9600;
        case (baud_rate_select)
            3'b000:  baud_rate_d = CLKS_9600;
            3'b001:  baud_rate_d = CLKS_14400;
            3'b010:  baud_rate_d = CLKS_19200;
            3'b011:  baud_rate_d = CLKS_38400;
            3'b100:  baud_rate_d = CLKS_57600;
            3'b101:  baud_rate_d = CLKS_115200;
            3'b110:  baud_rate_d = CLKS_128000;
            3'b111:  baud_rate_d = CLKS_256000;
            default: baud_rate_d = CLKS_9600;
        endcase
    end

    assign half_m1 = (div_q >> 1) - 11'd1;
    assign div_m1  = div_q - 11'd1;

    // prev_q lets IDLE demand a falling edge, so a held-low line cannot retrigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            prev_q    <= 1'b1;
        end else begin
            sync1_q   <= Rx_Serial;
            rx_sync_q <= sync1_q;
            prev_q    <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            div_q       <= CLKS_9600;
            clk_count_q <= 11'd0;
            bit_index_q <= 3'd0;
            shift_q     <= 8'h00;
            byte_q      <= 8'h00;
            done_q      <= 1'b0;
            fe_q        <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            fe_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_count_q <= 11'd0;
                    bit_index_q <= 3'd0;
                    if (!rx_sync_q && prev_q) begin
                        div_q    <= baud_rate_d;
                        active_q <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (clk_count_q < half_m1) begin
                        clk_count_q <= clk_count_q + 11'd1;
                    end else begin
                        clk_count_q <= 11'd0;
                        if (!rx_sync_q) begin
                            state_q <= S_DATA;
                        end else begin
                            active_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (clk_count_q < div_m1) begin
                        clk_count_q <= clk_count_q + 11'd1;
                    end else begin
                        clk_count_q          <= 11'd0;
                        shift_q[bit_index_q] <= rx_sync_q;
                        if (bit_index_q == 3'd7) begin
                            bit_index_q <= 3'd0;
                            state_q     <= S_STOP;
                        end else begin
                            bit_index_q <= bit_index_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (clk_count_q < div_m1) begin
                        clk_count_q <= clk_count_q + 11'd1;
                    end else begin
                        if (rx_sync_q) begin
                            byte_q <= shift_q;
                            done_q <= 1'b1;
                        end else begin
                            fe_q <= 1'b1;
                        end
                        active_q    <= 1'b0;
                        clk_count_q <= 11'd0;
                        state_q     <= S_CLEANUP;
                    end
                end
                S_CLEANUP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    active_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign Rx_Byte     = byte_q;
    assign Rx_Done     = done_q;
    assign Frame_Error = fe_q;
    assign Rx_Active   = active_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Directed self-checking bench for uart_rx.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic [2:0] baud_rate_select;
    logic       Rx_Serial;
    logic [7:0] Rx_Byte;
    logic       Rx_Done;
    logic       Frame_Error;
    logic       Rx_Active;

    int checks = 0;
    int errors = 0;

    int cyc      = 0;
    int t_fall   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    logic act_prev = 1'b0;

    uart_rx dut (
        .clk              (clk),
        .rst              (rst),
        .baud_rate_select (baud_rate_select),
        .Rx_Serial        (Rx_Serial),
        .Rx_Byte          (Rx_Byte),
        .Rx_Done          (Rx_Done),
        .Frame_Error      (Frame_Error),
        .Rx_Active        (Rx_Active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Rx_Done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (Frame_Error) fe_cnt = fe_cnt + 1;
        if (Rx_Done && Frame_Error) both_cnt = both_cnt + 1;
        if (Rx_Active && !act_prev) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        act_prev = Rx_Active;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame; optionally switches the select or pulses reset mid-frame.
    task automatic send_frame(input logic [7:0] data, input int div, input logic stop_val,
                              input int chg_bit, input int rst_bit);
        @(posedge clk);
        #1 Rx_Serial = 1'b0;
        t_fall = cyc;
        repeat (div) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 Rx_Serial = data[i];
            if (i == chg_bit) baud_rate_select = 3'b000;
            if (i == rst_bit) begin
                repeat (div / 2) @(posedge clk);
                #1 rst = 1'b0;
                Rx_Serial = 1'b1;
                #1;
                chk("rst_byte",   {24'd0, Rx_Byte}, 32'h00);
                chk("rst_done",   {31'd0, Rx_Done}, 32'd0);
                chk("rst_fe",     {31'd0, Frame_Error}, 32'd0);
                chk("rst_active", {31'd0, Rx_Active}, 32'd0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            repeat (div) @(posedge clk);
        end
        #1 Rx_Serial = stop_val;
        repeat (div) @(posedge clk);
        #1 Rx_Serial = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    function automatic int within_tol(input int diff, input int div);
        int e;
        e = 2 * diff - (19 * div + 8);
        if (e < 0) e = -e;
        return (e <= 4) ? 1 : 0;
    endfunction

    initial begin
        int divs [8];
        logic [7:0] pats [3];
        logic [7:0] last_byte;
        int d0, f0, r0;

        divs[0] = 1042; divs[1] = 695; divs[2] = 521; divs[3] = 261;
        divs[4] = 174;  divs[5] = 87;  divs[6] = 79;  divs[7] = 39;
        pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h55;

        rst = 1'b0;
        Rx_Serial = 1'b1;
        baud_rate_select = 3'b101;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_byte",   {24'd0, Rx_Byte}, 32'h00);
        chk("reset_done",   {31'd0, Rx_Done}, 32'd0);
        chk("reset_fe",     {31'd0, Frame_Error}, 32'd0);
        chk("reset_active", {31'd0, Rx_Active}, 32'd0);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Loopback 0xA5 at 87 clk/bit
        d0 = done_cnt; f0 = fe_cnt;
        send_frame(8'hA5, 87, 1'b1, -1, -1);
        chk("lb_done_cnt", done_cnt - d0, 1);
        chk("lb_fe_cnt",   fe_cnt - f0, 0);
        chk("lb_byte",     {24'd0, Rx_Byte}, 32'hA5);
        chk("lb_active",   {31'd0, Rx_Active}, 32'd0);
        chk("lb_act_lat",  rise_cyc - t_fall, 3);
        chk("lb_timing",   within_tol(done_cyc - t_fall, 87), 1);
        last_byte = 8'hA5;

        for (int s = 0; s < 8; s++) begin
            baud_rate_select = s[2:0];
            d0 = done_cnt;
            send_frame(pats[s % 3], divs[s], 1'b1, -1, -1);
            chk($sformatf("sel%0d_done", s), done_cnt - d0, 1);
            chk($sformatf("sel%0d_byte", s), {24'd0, Rx_Byte}, {24'd0, pats[s % 3]});
            chk($sformatf("sel%0d_time", s), within_tol(done_cyc - t_fall, divs[s]), 1);
            last_byte = pats[s % 3];
        end

        // Glitch of 10 clk at 87 clk/bit
        baud_rate_select = 3'b101;
        d0 = done_cnt; f0 = fe_cnt; r0 = rise_cnt;
        @(posedge clk);
        #1 Rx_Serial = 1'b0;
        repeat (10) @(posedge clk);
        #1 Rx_Serial = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("gl_rise",   rise_cnt - r0, 1);
        chk("gl_active", {31'd0, Rx_Active}, 32'd0);
        chk("gl_done",   done_cnt - d0, 0);
        chk("gl_fe",     fe_cnt - f0, 0);
        chk("gl_byte",   {24'd0, Rx_Byte}, {24'd0, last_byte});

        // Bad stop bit then a good frame
        d0 = done_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 87, 1'b0, -1, -1);
        chk("fe_cnt",  fe_cnt - f0, 1);
        chk("fe_done", done_cnt - d0, 0);
        chk("fe_byte", {24'd0, Rx_Byte}, {24'd0, last_byte});
        repeat (20) @(posedge clk);
        d0 = done_cnt;
        send_frame(8'h81, 87, 1'b1, -1, -1);
        chk("post_fe_done", done_cnt - d0, 1);
        chk("post_fe_byte", {24'd0, Rx_Byte}, 32'h81);

        // Select changes mid-frame; next frame runs at 1042
        d0 = done_cnt;
        send_frame(8'hC3, 87, 1'b1, 3, -1);
        chk("chg_done", done_cnt - d0, 1);
        chk("chg_byte", {24'd0, Rx_Byte}, 32'hC3);
        d0 = done_cnt;
        send_frame(8'h96, 1042, 1'b1, -1, -1);
        chk("slow_done", done_cnt - d0, 1);
        chk("slow_byte", {24'd0, Rx_Byte}, 32'h96);
        chk("slow_time", within_tol(done_cyc - t_fall, 1042), 1);

        // Reset during data bit 4, then a clean frame
        baud_rate_select = 3'b101;
        d0 = done_cnt; f0 = fe_cnt;
        send_frame(8'hE7, 87, 1'b1, -1, 4);
        repeat (30) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_fe",   fe_cnt - f0, 0);
        chk("rst_idle",    {31'd0, Rx_Active}, 32'd0);
        d0 = done_cnt;
        send_frame(8'h7E, 87, 1'b1, -1, -1);
        chk("rst_after_done", done_cnt - d0, 1);
        chk("rst_after_byte", {24'd0, Rx_Byte}, 32'h7E);

        chk("excl_done_fe", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
